// File: rtl/pipe_pkg.sv
// Shared constants for inter-stage pipeline registers: bubble instruction,
// reset PC and the control-state encoding (bit0 = main valid, bit1 = skid valid).
package pipe_pkg;

  // Bubble instruction; switch to 32'h0000_0013 for the canonical RISC-V addi x0,x0,0.
  localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PIPE_RESET_PC  = 32'hFFFF_FFFC;

  localparam int unsigned STATE_WIDTH = 2;

  localparam logic [STATE_WIDTH-1:0] EMPTY = 2'b00;
  localparam logic [STATE_WIDTH-1:0] FULL1 = 2'b01;
  localparam logic [STATE_WIDTH-1:0] FULL2 = 2'b11;

  // Decoded occupancy helpers; the state encoding doubles as the valid bits.
  function automatic logic state_main_valid(input logic [STATE_WIDTH-1:0] s);
    return s[0];
  endfunction

  function automatic logic state_skid_valid(input logic [STATE_WIDTH-1:0] s);
    return s[1];
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry (instruction, PC, payload) with load, bubble and clear.
// Priority: clear > bubble > load; bubble replaces only the instruction.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int unsigned              INSTR_WIDTH   = 32,
  parameter int unsigned              PC_WIDTH      = 32,
  parameter int unsigned              PAYLOAD_WIDTH = 64,
  parameter logic [INSTR_WIDTH-1:0]   NOP_INSTR     = INSTR_WIDTH'(PIPE_NOP_INSTR),
  parameter logic [PC_WIDTH-1:0]      RESET_PC      = PC_WIDTH'(PIPE_RESET_PC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     bubble,
  input  logic                     clear,
  input  logic [INSTR_WIDTH-1:0]   d_instr,
  input  logic [PC_WIDTH-1:0]      d_pc,
  input  logic [PAYLOAD_WIDTH-1:0] d_payload,
  output logic [INSTR_WIDTH-1:0]   q_instr,
  output logic [PC_WIDTH-1:0]      q_pc,
  output logic [PAYLOAD_WIDTH-1:0] q_payload
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_instr   <= NOP_INSTR;
      q_pc      <= RESET_PC;
      q_payload <= '0;
    end else if (clear) begin
      q_instr   <= NOP_INSTR;
      q_pc      <= RESET_PC;
      q_payload <= '0;
    end else if (bubble) begin
      q_instr   <= NOP_INSTR;
    end else if (load) begin
      q_instr   <= d_instr;
      q_pc      <= d_pc;
      q_payload <= d_payload;
    end
  end

endmodule

// File: rtl/pipeline_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid
// buffer, global BUSY_WAIT freeze, synchronous FLUSH and a saturating stall counter.
module pipeline_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned              INSTR_WIDTH   = 32,
  parameter int unsigned              PC_WIDTH      = 32,
  parameter int unsigned              PAYLOAD_WIDTH = 64,
  parameter logic [INSTR_WIDTH-1:0]   NOP_INSTR     = INSTR_WIDTH'(PIPE_NOP_INSTR),
  parameter logic [PC_WIDTH-1:0]      RESET_PC      = PC_WIDTH'(PIPE_RESET_PC),
  parameter int unsigned              CNT_WIDTH     = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     BUSY_WAIT,
  input  logic                     FLUSH,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [INSTR_WIDTH-1:0]   IN_INSTRUCTION,
  input  logic [PC_WIDTH-1:0]      IN_PC,
  input  logic [PAYLOAD_WIDTH-1:0] IN_PAYLOAD,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [INSTR_WIDTH-1:0]   OUT_INSTRUCTION,
  output logic [PC_WIDTH-1:0]      OUT_PC,
  output logic [PAYLOAD_WIDTH-1:0] OUT_PAYLOAD,
  output logic [CNT_WIDTH-1:0]     STALL_COUNT
);

  logic [STATE_WIDTH-1:0]   state;
  logic [STATE_WIDTH-1:0]   state_next;
  logic                     main_valid;
  logic                     skid_valid;
  logic                     in_fire;
  logic                     out_fire;
  logic                     main_load;
  logic                     main_bubble;
  logic                     main_from_skid;
  logic                     skid_load;
  logic                     skid_clear;
  logic                     stall_inc;
  logic [CNT_WIDTH-1:0]     stall_cnt;

  logic [INSTR_WIDTH-1:0]   skid_instr;
  logic [PC_WIDTH-1:0]      skid_pc;
  logic [PAYLOAD_WIDTH-1:0] skid_payload;
  logic [INSTR_WIDTH-1:0]   main_d_instr;
  logic [PC_WIDTH-1:0]      main_d_pc;
  logic [PAYLOAD_WIDTH-1:0] main_d_payload;

  assign main_valid = state_main_valid(state);
  assign skid_valid = state_skid_valid(state);

  // Ready depends only on local state and the freeze, never on OUT_READY.
  assign IN_READY = ~skid_valid & ~BUSY_WAIT;
  assign in_fire  = IN_VALID & IN_READY;
  assign out_fire = main_valid & OUT_READY & ~BUSY_WAIT;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and entry-register control.
  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_bubble    = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (FLUSH) begin
      state_next  = EMPTY;
      main_bubble = 1'b1;
      skid_clear  = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_next = FULL1;
            main_load  = 1'b1;
          end
        end
        FULL1: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_next = FULL2;
            skid_load  = 1'b1;
          end else if (out_fire) begin
            state_next  = EMPTY;
            main_bubble = 1'b1;
          end
        end
        FULL2: begin
          if (out_fire) begin
            state_next     = FULL1;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          state_next  = EMPTY;
          main_bubble = 1'b1;
          skid_clear  = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    main_d_instr   = IN_INSTRUCTION;
    main_d_pc      = IN_PC;
    main_d_payload = IN_PAYLOAD;
    if (main_from_skid) begin
      main_d_instr   = skid_instr;
      main_d_pc      = skid_pc;
      main_d_payload = skid_payload;
    end
  end

  pipe_entry_reg #(
    .INSTR_WIDTH   (INSTR_WIDTH),
    .PC_WIDTH      (PC_WIDTH),
    .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
    .NOP_INSTR     (NOP_INSTR),
    .RESET_PC      (RESET_PC)
  ) u_main (
    .clk       (CLK),
    .rst_n     (RESET),
    .load      (main_load),
    .bubble    (main_bubble),
    .clear     (1'b0),
    .d_instr   (main_d_instr),
    .d_pc      (main_d_pc),
    .d_payload (main_d_payload),
    .q_instr   (OUT_INSTRUCTION),
    .q_pc      (OUT_PC),
    .q_payload (OUT_PAYLOAD)
  );

  pipe_entry_reg #(
    .INSTR_WIDTH   (INSTR_WIDTH),
    .PC_WIDTH      (PC_WIDTH),
    .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
    .NOP_INSTR     (NOP_INSTR),
    .RESET_PC      (RESET_PC)
  ) u_skid (
    .clk       (CLK),
    .rst_n     (RESET),
    .load      (skid_load),
    .bubble    (1'b0),
    .clear     (skid_clear),
    .d_instr   (IN_INSTRUCTION),
    .d_pc      (IN_PC),
    .d_payload (IN_PAYLOAD),
    .q_instr   (skid_instr),
    .q_pc      (skid_pc),
    .q_payload (skid_payload)
  );

  assign OUT_VALID = main_valid;

  // Saturating count of cycles where a held item was not drained.
  assign stall_inc = main_valid & (~OUT_READY | BUSY_WAIT) & ~FLUSH;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stall_cnt <= '0;
    end else if (stall_inc && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

  assign STALL_COUNT = stall_cnt;

endmodule

// File: tb/tb_pipeline_skid_reg.sv
// Randomised and directed bench for pipeline_skid_reg against a queue-based model.
module tb_pipeline_skid_reg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [63:0] pay;
  } item_t;

  logic        CLK;
  logic        RESET;
  logic        BUSY_WAIT;
  logic        FLUSH;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_INSTRUCTION;
  logic [31:0] IN_PC;
  logic [63:0] IN_PAYLOAD;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_INSTRUCTION;
  logic [31:0] OUT_PC;
  logic [63:0] OUT_PAYLOAD;
  logic [15:0] STALL_COUNT;

  logic        sat_in_ready;
  logic        sat_valid;
  logic [31:0] sat_instr;
  logic [31:0] sat_pc;
  logic [63:0] sat_payload;
  logic [1:0]  sat_count;

  pipeline_skid_reg u_dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .BUSY_WAIT       (BUSY_WAIT),
    .FLUSH           (FLUSH),
    .IN_VALID        (IN_VALID),
    .IN_READY        (IN_READY),
    .IN_INSTRUCTION  (IN_INSTRUCTION),
    .IN_PC           (IN_PC),
    .IN_PAYLOAD      (IN_PAYLOAD),
    .OUT_VALID       (OUT_VALID),
    .OUT_READY       (OUT_READY),
    .OUT_INSTRUCTION (OUT_INSTRUCTION),
    .OUT_PC          (OUT_PC),
    .OUT_PAYLOAD     (OUT_PAYLOAD),
    .STALL_COUNT     (STALL_COUNT)
  );

  pipeline_skid_reg #(.CNT_WIDTH(2)) u_sat (
    .CLK             (CLK),
    .RESET           (RESET),
    .BUSY_WAIT       (BUSY_WAIT),
    .FLUSH           (FLUSH),
    .IN_VALID        (IN_VALID),
    .IN_READY        (sat_in_ready),
    .IN_INSTRUCTION  (IN_INSTRUCTION),
    .IN_PC           (IN_PC),
    .IN_PAYLOAD      (IN_PAYLOAD),
    .OUT_VALID       (sat_valid),
    .OUT_READY       (OUT_READY),
    .OUT_INSTRUCTION (sat_instr),
    .OUT_PC          (sat_pc),
    .OUT_PAYLOAD     (sat_payload),
    .STALL_COUNT     (sat_count)
  );

  initial begin
    CLK = 1'b0;
    #20;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: ordered queue of held items (at most two) plus the
  // PC/payload last shown on OUT, which persist when the stage empties.
  item_t q[$];
  logic [31:0] disp_pc;
  logic [63:0] disp_pay;
  int cnt16;
  int cnt2;
  int seq = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    disp_pc  = 32'hFFFF_FFFC;
    disp_pay = '0;
    cnt16    = 0;
    cnt2     = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic        ev;
    logic [31:0] ei;
    ev = (q.size() > 0);
    ei = ev ? q[0].instr : 32'h0;
    check({tag, ".valid"},   64'(OUT_VALID),       64'(ev));
    check({tag, ".instr"},   64'(OUT_INSTRUCTION), 64'(ei));
    check({tag, ".pc"},      64'(OUT_PC),          64'(disp_pc));
    check({tag, ".payload"}, OUT_PAYLOAD,          disp_pay);
    check({tag, ".stall"},   64'(STALL_COUNT),     64'(cnt16));
    check({tag, ".sat_valid"}, 64'(sat_valid),     64'(ev));
    check({tag, ".sat_stall"}, 64'(sat_count),     64'(cnt2));
  endtask

  // One clock: drive inputs, check ready, advance model across the edge, check outputs.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [63:0] pay, input logic ordy, input logic busy,
                       input logic flush, input string tag);
    logic  rdy;
    logic  fin;
    logic  fout;
    logic  stall;
    item_t it;
    IN_VALID       = iv;
    IN_INSTRUCTION = ins;
    IN_PC          = pc;
    IN_PAYLOAD     = pay;
    OUT_READY      = ordy;
    BUSY_WAIT      = busy;
    FLUSH          = flush;
    #1;
    rdy   = (q.size() < 2) && !busy;
    fin   = iv && rdy;
    fout  = (q.size() > 0) && ordy && !busy;
    stall = (q.size() > 0) && (!ordy || busy) && !flush;
    check({tag, ".in_ready"}, 64'(IN_READY), 64'(rdy));
    @(posedge CLK);
    #1;
    if (stall) begin
      if (cnt16 < 65535) cnt16++;
      if (cnt2 < 3) cnt2++;
    end
    if (flush) begin
      q.delete();
    end else begin
      if (fout) void'(q.pop_front());
      if (fin) begin
        it.instr = ins;
        it.pc    = pc;
        it.pay   = pay;
        q.push_back(it);
      end
    end
    if (q.size() > 0) begin
      disp_pc  = q[0].pc;
      disp_pay = q[0].pay;
    end
    check_outputs(tag);
  endtask

  task automatic async_reset(input string tag);
    IN_VALID  = 1'b0;
    BUSY_WAIT = 1'b0;
    FLUSH     = 1'b0;
    RESET     = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    check({tag, ".in_ready"}, 64'(IN_READY), 64'(1'b1));
    #2;
    RESET = 1'b1;
  endtask

  initial begin
    RESET          = 1'b1;
    BUSY_WAIT      = 1'b0;
    FLUSH          = 1'b0;
    IN_VALID       = 1'b0;
    IN_INSTRUCTION = '0;
    IN_PC          = '0;
    IN_PAYLOAD     = '0;
    OUT_READY      = 1'b0;
    model_reset();

    // Reset with the clock idle.
    #1;
    RESET = 1'b0;
    #1;
    check("rst.valid", 64'(OUT_VALID), 64'(1'b0));
    check("rst.instr", 64'(OUT_INSTRUCTION), 64'h0);
    check("rst.pc", 64'(OUT_PC), 64'hFFFF_FFFC);
    check("rst.stall", 64'(STALL_COUNT), 64'h0);
    check("rst.in_ready", 64'(IN_READY), 64'h1);
    #10;
    RESET = 1'b1;

    // Streaming at full rate.
    cycle(1'b1, 32'd16, 32'd25, 64'hA0, 1'b1, 1'b0, 1'b0, "s1");
    check("stream0", 64'(OUT_INSTRUCTION), 64'd16);
    cycle(1'b1, 32'd17, 32'd29, 64'hA1, 1'b1, 1'b0, 1'b0, "s2");
    check("stream1", 64'(OUT_INSTRUCTION), 64'd17);
    cycle(1'b1, 32'd18, 32'd33, 64'hA2, 1'b1, 1'b0, 1'b0, "s3");
    check("stream2", 64'(OUT_PC), 64'd33);
    cycle(1'b0, 32'd0, 32'd0, 64'h0, 1'b1, 1'b0, 1'b0, "s_drain");

    // Back-pressure fills the skid entry.
    cycle(1'b1, 32'd3, 32'd100, 64'hB0, 1'b0, 1'b0, 1'b0, "bp1");
    cycle(1'b1, 32'd80, 32'd104, 64'hB1, 1'b0, 1'b0, 1'b0, "bp2");
    cycle(1'b1, 32'd99, 32'd108, 64'hB2, 1'b0, 1'b0, 1'b0, "bp3");
    check("bp.main", 64'(OUT_INSTRUCTION), 64'd3);
    cycle(1'b0, 32'd0, 32'd0, 64'h0, 1'b1, 1'b0, 1'b0, "bp4");
    check("bp.second", 64'(OUT_INSTRUCTION), 64'd80);
    cycle(1'b0, 32'd0, 32'd0, 64'h0, 1'b1, 1'b0, 1'b0, "bp5");

    // Freeze while holding one item.
    cycle(1'b1, 32'd16, 32'd25, 64'hC0, 1'b1, 1'b0, 1'b0, "bw0");
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'd3, 32'd80, 64'hC1, 1'b1, 1'b1, 1'b0, "bw");
    check("bw.hold", 64'(OUT_INSTRUCTION), 64'd16);
    cycle(1'b1, 32'd3, 32'd80, 64'hC1, 1'b1, 1'b0, 1'b0, "bw_rel");
    check("bw.accept", 64'(OUT_PC), 64'd80);
    cycle(1'b0, 32'd0, 32'd0, 64'h0, 1'b1, 1'b0, 1'b0, "bw_drain");

    // Flush from FULL2 under BUSY_WAIT.
    cycle(1'b1, 32'd40, 32'd200, 64'hD0, 1'b0, 1'b0, 1'b0, "fl1");
    cycle(1'b1, 32'd41, 32'd204, 64'hD1, 1'b0, 1'b0, 1'b0, "fl2");
    cycle(1'b1, 32'd42, 32'd208, 64'hD2, 1'b0, 1'b1, 1'b1, "fl3");
    cycle(1'b0, 32'd0, 32'd0, 64'h0, 1'b1, 1'b0, 1'b0, "fl4");
    cycle(1'b0, 32'd0, 32'd0, 64'h0, 1'b1, 1'b0, 1'b0, "fl5");

    // Async reset while in FULL2, then counter saturation.
    cycle(1'b1, 32'd50, 32'd300, 64'hE0, 1'b0, 1'b0, 1'b0, "ar1");
    cycle(1'b1, 32'd51, 32'd304, 64'hE1, 1'b0, 1'b0, 1'b0, "ar2");
    #2;
    async_reset("ar");
    cycle(1'b1, 32'd60, 32'd400, 64'hF0, 1'b0, 1'b0, 1'b0, "sat0");
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'd0, 32'd0, 64'h0, 1'b0, 1'b0, 1'b0, "sat");
    check("sat.cnt2", 64'(sat_count), 64'd3);
    check("sat.cnt16", 64'(STALL_COUNT), 64'd6);
    cycle(1'b0, 32'd0, 32'd0, 64'h0, 1'b1, 1'b0, 1'b0, "sat_drain");

    // Random traffic with occasional freeze, flush and async reset.
    for (int n = 0; n < 3000; n++) begin
      logic iv;
      logic ordy;
      logic busy;
      logic flush;
      iv    = ($urandom_range(0, 3) != 0);
      ordy  = ($urandom_range(0, 2) != 0);
      busy  = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 19) == 0);
      seq++;
      cycle(iv, 32'(seq) ^ 32'h1000_0000, 32'(seq * 4), {$urandom, $urandom},
            ordy, busy, flush, "rnd");
      if ((n % 700) == 699) begin
        #2;
        async_reset("rnd_rst");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
